// File: rtl/frame_cfg_pkg.sv
// rtl/frame_cfg_pkg.sv - shared types and constants for the column frame configuration loader
//
// Purpose: loader state encoding, sync/desync words and command field layout,
// shared by frame_config_loader and frame_strobe_decoder.
package frame_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_DATA   = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [WORD_W-1:0] DESYNC_WORD = 32'hFAB0_FAB0;

    // Command word layout: frame index in the low byte, upper bits reserved.
    localparam int CMD_IDX_LSB = 0;
    localparam int CMD_IDX_W   = 8;

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - frame index to one-hot latch strobe decoder
//
// Purpose: combinational decode of a frame index into a one-hot strobe vector.
// Indices at or beyond NumFrames decode to all-zero, as does en_i low.
// Ports:
//   idx_i     in   CMD_IDX_W   frame index
//   en_i      in   1           decode enable
//   onehot_o  out  NumFrames   one-hot strobe, all zero when disabled/out of range
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int NumFrames = 20
) (
    input  logic [CMD_IDX_W-1:0] idx_i,
    input  logic                 en_i,
    output logic [NumFrames-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NumFrames; i++) begin
            onehot_o[i] = en_i && ({24'd0, idx_i} == 32'(i));
        end
    end

endmodule

// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - bitstream word stream to column frame + one-hot latch strobe
//
// Purpose: hunts for the sync word, then per command assembles NumRows data words
// into FrameData and pulses one FrameStrobe bit for a single cycle.
// Ports:
//   CLK          in   1                          clock
//   RST          in   1                          asynchronous active-high reset
//   WordIn       in   32                         bitstream word
//   WordValid    in   1                          WordIn valid
//   WordReady    out  1                          WordIn accepted this cycle
//   FrameData    out  NumRows*FrameBitsPerRow    assembled frame, row r at [r*32 +: 32]
//   FrameStrobe  out  MaxFramesPerCol            one-hot latch strobe
//   Busy         out  1                          not in IDLE
//   Err          out  1                          sticky out-of-range command flag
module frame_config_loader
    import frame_cfg_pkg::*;
#(
    parameter int                 FrameBitsPerRow = 32,
    parameter int                 MaxFramesPerCol = 20,
    parameter int                 NumRows         = 4,
    parameter logic [WORD_W-1:0]  SyncWord        = SYNC_WORD,
    parameter logic [WORD_W-1:0]  DesyncWord      = DESYNC_WORD
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [WORD_W-1:0]                   WordIn,
    input  logic                                WordValid,
    output logic                                WordReady,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]          FrameStrobe,
    output logic                                Busy,
    output logic                                Err
);

    localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;

    state_e                               state_q, state_d;
    logic [RW-1:0]                        rowcnt_q, rowcnt_d;
    logic [CMD_IDX_W-1:0]                 idx_q, idx_d;
    logic                                 drop_q, drop_d;
    logic                                 err_q, err_d;
    logic                                 ready_en_q;
    logic [NumRows*FrameBitsPerRow-1:0]   frame_q, frame_d;
    logic [MaxFramesPerCol-1:0]           strobe_q, strobe_d;
    logic [CMD_IDX_W-1:0]                 cmd_idx;
    logic                                 xfer;

    assign cmd_idx = WordIn[CMD_IDX_LSB +: CMD_IDX_W];

    // ready_en_q holds WordReady low for the first cycle after reset release.
    assign WordReady = ready_en_q &&
                       (state_q == ST_IDLE || state_q == ST_CMD || state_q == ST_DATA);
    assign xfer      = WordValid && WordReady;

    always_comb begin
        state_d  = state_q;
        rowcnt_d = rowcnt_q;
        idx_d    = idx_q;
        drop_d   = drop_q;
        err_d    = err_q;
        frame_d  = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && WordIn == SyncWord) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (xfer) begin
                    if (WordIn == DesyncWord) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d    = cmd_idx;
                        rowcnt_d = '0;
                        state_d  = ST_DATA;
                        drop_d   = ({24'd0, cmd_idx} >= 32'(MaxFramesPerCol));
                        if (drop_d) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    for (int r = 0; r < NumRows; r++) begin
                        if (rowcnt_q == RW'(r)) begin
                            frame_d[r*FrameBitsPerRow +: FrameBitsPerRow] = WordIn;
                        end
                    end
                    if (rowcnt_q == RW'(NumRows - 1)) begin
                        state_d = ST_STROBE;
                    end else begin
                        rowcnt_d = rowcnt_q + 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                drop_d  = 1'b0;
                state_d = ST_CMD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The strobe is registered from the next state so it is glitch-free and
    // coincides exactly with the STROBE state.
    frame_strobe_decoder #(
        .NumFrames (MaxFramesPerCol)
    ) u_strobe_dec (
        .idx_i    (idx_q),
        .en_i     ((state_d == ST_STROBE) && !drop_q),
        .onehot_o (strobe_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            rowcnt_q   <= '0;
            idx_q      <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
            frame_q    <= '0;
            strobe_q   <= '0;
        end else begin
            state_q    <= state_d;
            rowcnt_q   <= rowcnt_d;
            idx_q      <= idx_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
            frame_q    <= frame_d;
            strobe_q   <= strobe_d;
        end
    end

    assign FrameData   = frame_q;
    assign FrameStrobe = strobe_q;
    assign Busy        = (state_q != ST_IDLE);
    assign Err         = err_q;

endmodule

// File: tb/tb_frame_config_loader.sv
// tb/tb_frame_config_loader.sv - scoreboard testbench for frame_config_loader
module tb_frame_config_loader;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [31:0]   WordIn = '0;
    logic          WordValid = 1'b0;
    logic          WordReady;
    logic [127:0]  FrameData;
    logic [19:0]   FrameStrobe;
    logic          Busy;
    logic          Err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [19:0]  strobe;
        logic [127:0] data;
        int           at_cyc;
    } exp_t;

    exp_t exp_q[$];

    frame_config_loader dut (
        .CLK         (CLK),
        .RST         (RST),
        .WordIn      (WordIn),
        .WordValid   (WordValid),
        .WordReady   (WordReady),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .Busy        (Busy),
        .Err         (Err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every nonzero strobe must match the head of the expected queue.
    logic [127:0] strobe_data;
    logic         chk_after = 1'b0;
    always @(negedge CLK) begin
        if (!RST) begin
            if (FrameStrobe != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {108'd0, FrameStrobe}, 128'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe_value", {108'd0, FrameStrobe}, {108'd0, e.strobe});
                    check("strobe_data", FrameData, e.data);
                    check("strobe_cycle", 128'(cyc), 128'(e.at_cyc));
                end
                strobe_data = FrameData;
                chk_after   = 1'b1;
            end else if (chk_after) begin
                check("data_after_strobe", FrameData, strobe_data);
                chk_after = 1'b0;
            end
        end else begin
            chk_after = 1'b0;
        end
    end

    // Drives one word until it transfers; tcyc is the transfer cycle number.
    task automatic send(input logic [31:0] w, output int tcyc);
        int guard = 0;
        WordIn    = w;
        WordValid = 1'b1;
        forever begin
            @(negedge CLK);
            if (WordReady) break;
            guard++;
            if (guard > 200) begin
                check("ready_timeout", 128'd0, 128'd1);
                break;
            end
        end
        tcyc = cyc;
        @(posedge CLK);
        #1;
        WordValid = 1'b0;
    endtask

    task automatic idle_cycle();
        WordValid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] cmd, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input bit gaps,
                              input bit expect_strobe, input logic [19:0] stb, output int tcyc);
        int t;
        logic [31:0] d [4];
        exp_t e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        send(cmd, t);
        for (int i = 0; i < 4; i++) begin
            if (gaps) idle_cycle();
            send(d[i], t);
        end
        tcyc = t;
        if (expect_strobe) begin
            e.strobe = stb;
            e.data   = {d3, d2, d1, d0};
            e.at_cyc = t + 1;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, t1;
        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", {127'd0, WordReady}, 128'd0);
        check("rst_data", FrameData, 128'd0);
        check("rst_strobe", {108'd0, FrameStrobe}, 128'd0);
        check("rst_busy", {127'd0, Busy}, 128'd0);
        check("rst_err", {127'd0, Err}, 128'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("ready_first_cycle", {127'd0, WordReady}, 128'd0);
        @(negedge CLK);
        check("ready_after_release", {127'd0, WordReady}, 128'd1);
        @(posedge CLK); #1;

        // 1: basic frame, index 3
        send(32'hFAB0_FAB1, t);
        send_frame(32'h0000_0003, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                   1'b0, 1'b1, 20'h00008, t);
        @(negedge CLK);
        check("s1_ready_strobe", {127'd0, WordReady}, 128'd0);
        @(negedge CLK);
        check("s1_ready_hold", {127'd0, WordReady}, 128'd0);
        @(negedge CLK);
        check("s1_ready_cmd", {127'd0, WordReady}, 128'd1);
        check("s1_data", FrameData, 128'h44444444_33333333_22222222_11111111);
        check("s1_busy", {127'd0, Busy}, 128'd1);
        @(posedge CLK); #1;
        send(32'hFAB0_FAB0, t);

        // 2: non-sync words in IDLE are discarded
        send(32'h1234_5678, t);
        @(negedge CLK);
        check("s2_busy_a", {127'd0, Busy}, 128'd0);
        @(posedge CLK); #1;
        send(32'hFAB0_FAB0, t);
        @(negedge CLK);
        check("s2_busy_b", {127'd0, Busy}, 128'd0);
        @(posedge CLK); #1;

        // 3: out-of-range index sets Err, no strobe; following frame still strobes
        send(32'hFAB0_FAB1, t);
        send(32'h0000_0014, t);
        check("s3_err_set", {127'd0, Err}, 128'd1);
        send(32'hAAAA_0001, t);
        send(32'hAAAA_0002, t);
        send(32'hAAAA_0003, t);
        send(32'hAAAA_0004, t);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("s3_drop_data", FrameData, 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001);
        @(posedge CLK); #1;
        send_frame(32'h0000_0000, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888,
                   1'b0, 1'b1, 20'h00001, t);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("s3_err_sticky", {127'd0, Err}, 128'd1);
        @(posedge CLK); #1;
        send(32'hFAB0_FAB0, t);

        // 4: back-to-back frames then desync; DesyncWord as data is stored
        send(32'hFAB0_FAB1, t);
        send_frame(32'h0000_0000, 32'h0102_0304, 32'hFAB0_FAB0, 32'h0506_0708, 32'h090A_0B0C,
                   1'b0, 1'b1, 20'h00001, t0);
        send_frame(32'h0000_0013, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0BAD_F00D, 32'hFEED_FACE,
                   1'b0, 1'b1, 20'h80000, t1);
        check("s4_frame_period", 128'(t1 - t0), 128'd7);
        send(32'hFAB0_FAB0, t);
        @(negedge CLK);
        check("s4_busy_idle", {127'd0, Busy}, 128'd0);
        @(posedge CLK); #1;

        // 5: WordValid toggling during DATA
        send(32'hFAB0_FAB1, t);
        send_frame(32'h0000_0003, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                   1'b1, 1'b1, 20'h00008, t);
        repeat (3) @(posedge CLK);
        #1;

        // 6: reset during the STROBE cycle
        send_frame(32'h0000_0005, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
                   1'b0, 1'b0, 20'h0, t);
        check("s6_strobe_live", {108'd0, FrameStrobe}, 128'h20);
        RST = 1'b1;
        #1;
        check("s6_strobe_reset", {108'd0, FrameStrobe}, 128'd0);
        check("s6_data_reset", FrameData, 128'd0);
        check("s6_err_reset", {127'd0, Err}, 128'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        send_frame(32'h0000_0002, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 1'b0, 20'h0, t);
        @(negedge CLK);
        check("s6_needs_sync", {127'd0, Busy}, 128'd0);
        @(posedge CLK); #1;
        send(32'hFAB0_FAB1, t);
        send_frame(32'h0000_0002, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3, 32'hD4D4_D4D4,
                   1'b0, 1'b1, 20'h00004, t);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check("all_strobes_seen", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
